// File: rtl/native_axi_master.sv
// Bridge from a native valid/ready memory port to AXI4-lite, one transaction at a time.
// Every output is driven from a flop; the FSM computes next values, a single register stage holds them.
module native_axi_master (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, addr_nxt, wdata_q, wdata_nxt, rdata_q, rdata_nxt;
  logic [3:0]  wstrb_q, wstrb_nxt;
  logic        instr_q, instr_nxt;
  logic        aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic        arvalid_nxt, awvalid_nxt, wvalid_nxt, rready_nxt, bready_nxt, ready_nxt;
  logic        aw_fin, w_fin;

  // Latched request fields feed the AXI address/data/prot outputs directly.
  assign mem_axi_araddr = addr_q;
  assign mem_axi_awaddr = addr_q;
  assign mem_axi_wdata  = wdata_q;
  assign mem_axi_wstrb  = wstrb_q;
  assign mem_axi_arprot = {instr_q, 2'b00};
  assign mem_axi_awprot = 3'b000;
  assign mem_rdata      = rdata_q;

  assign aw_fin = aw_done | (mem_axi_awvalid & mem_axi_awready);
  assign w_fin  = w_done  | (mem_axi_wvalid  & mem_axi_wready);

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    wstrb_nxt   = wstrb_q;
    instr_nxt   = instr_q;
    rdata_nxt   = rdata_q;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    arvalid_nxt = mem_axi_arvalid;
    awvalid_nxt = mem_axi_awvalid;
    wvalid_nxt  = mem_axi_wvalid;
    rready_nxt  = mem_axi_rready;
    bready_nxt  = mem_axi_bready;
    ready_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_valid) begin
          addr_nxt    = mem_addr;
          wdata_nxt   = mem_wdata;
          wstrb_nxt   = mem_wstrb;
          instr_nxt   = mem_instr;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          if (mem_wstrb == 4'b0000) begin
            arvalid_nxt = 1'b1;
            state_nxt   = RD_ADDR;
          end else begin
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_REQ;
          end
        end
      end
      RD_ADDR: begin
        if (mem_axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (mem_axi_rvalid) begin
          rdata_nxt  = mem_axi_rdata;
          rready_nxt = 1'b0;
          ready_nxt  = 1'b1;
          state_nxt  = DONE;
        end
      end
      WR_REQ: begin
        // Address and data channels complete independently; either order, or together.
        if (mem_axi_awvalid && mem_axi_awready) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (mem_axi_wvalid && mem_axi_wready) begin
          wvalid_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        if (aw_fin && w_fin) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (mem_axi_bvalid) begin
          bready_nxt = 1'b0;
          ready_nxt  = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      instr_q         <= 1'b0;
      rdata_q         <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_rready  <= 1'b0;
      mem_axi_bready  <= 1'b0;
      mem_ready       <= 1'b0;
    end else begin
      state           <= state_nxt;
      addr_q          <= addr_nxt;
      wdata_q         <= wdata_nxt;
      wstrb_q         <= wstrb_nxt;
      instr_q         <= instr_nxt;
      rdata_q         <= rdata_nxt;
      aw_done         <= aw_done_nxt;
      w_done          <= w_done_nxt;
      mem_axi_arvalid <= arvalid_nxt;
      mem_axi_awvalid <= awvalid_nxt;
      mem_axi_wvalid  <= wvalid_nxt;
      mem_axi_rready  <= rready_nxt;
      mem_axi_bready  <= bready_nxt;
      mem_ready       <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_native_axi_master.sv
// Bench for native_axi_master: delay-configurable AXI responder, word-level memory reference model,
// directed scenarios plus randomized reads/writes.
module tb_native_axi_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;

  native_axi_master dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_awprot(awprot), .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb), .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
    .mem_axi_arprot(arprot), .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
    .mem_axi_rdata(rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // Responder knobs: number of cycles a valid/ready is seen before the answer comes.
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  bit spur = 1'b0;

  logic [31:0] resp_mem [int];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = '0;

  int ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
  int ar_hi = 0, aw_hi = 0, w_hi = 0, pulses = 0, act = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
  logic [31:0] last_araddr = '0;
  logic [2:0]  last_arprot = '0, last_awprot = '0;
  bit          aw_pend = 0, w_pend = 0, ar_wait = 0, aw_wait = 0, w_wait = 0;
  logic [31:0] pend_addr = '0, pend_data = '0, p_araddr = '0, p_awaddr = '0, p_wdata = '0;
  logic [3:0]  pend_strb = '0, p_wstrb = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    int k;
    k = int'(a >> 2);
    return resp_mem.exists(k) ? resp_mem[k] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int k;
    k = int'(a >> 2);
    return ref_mem.exists(k) ? ref_mem[k] : dflt(a);
  endfunction

  // Responder and protocol monitor; outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (!resetn) begin
      arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      aw_pend = 0; w_pend = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
    end else begin
      if (ar_wait) begin
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== p_araddr) begin
          n_fail++;
          $display("FAIL ar_stable: arvalid=%b araddr=%h required 1/%h", arvalid, araddr, p_araddr);
        end
      end
      if (aw_wait) begin
        n_checks++;
        if (awvalid !== 1'b1 || awaddr !== p_awaddr) begin
          n_fail++;
          $display("FAIL aw_stable: awvalid=%b awaddr=%h required 1/%h", awvalid, awaddr, p_awaddr);
        end
      end
      if (w_wait) begin
        n_checks++;
        if (wvalid !== 1'b1 || wdata !== p_wdata || wstrb !== p_wstrb) begin
          n_fail++;
          $display("FAIL w_stable: wvalid=%b wdata=%h wstrb=%b required 1/%h/%b",
                   wvalid, wdata, wstrb, p_wdata, p_wstrb);
        end
      end
      if (arvalid || awvalid) begin
        n_checks++;
        if (arvalid && awvalid) begin
          n_fail++;
          $display("FAIL ar_aw_exclusive: arvalid=%b awvalid=%b required not both", arvalid, awvalid);
        end
      end
      ar_hi  += int'(arvalid);
      aw_hi  += int'(awvalid);
      w_hi   += int'(wvalid);
      pulses += int'(mem_ready);
      act    += int'(arvalid | awvalid | wvalid | rready | bready | mem_ready);

      ar_cnt  = arvalid ? ar_cnt + 1 : 0;
      arready = arvalid && (ar_cnt > ar_delay);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      awready = awvalid && (aw_cnt > aw_delay);
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      wready  = wvalid && (w_cnt > w_delay);
      r_cnt   = rready ? r_cnt + 1 : 0;
      rvalid  = (rready && (r_cnt > r_delay)) || spur;
      rdata   = (spur && !rready) ? 32'hBAD0_BAD0 : resp_rd(araddr);
      b_cnt   = bready ? b_cnt + 1 : 0;
      bvalid  = (bready && (b_cnt > b_delay)) || spur;

      ar_wait = arvalid && !arready; p_araddr = araddr;
      aw_wait = awvalid && !awready; p_awaddr = awaddr;
      w_wait  = wvalid && !wready;   p_wdata = wdata; p_wstrb = wstrb;
      if (arvalid && arready) begin
        ar_hs++; last_araddr = araddr; last_arprot = arprot;
      end
      if (awvalid && awready) begin
        aw_hs++; aw_pend = 1; pend_addr = awaddr; last_awprot = awprot;
      end
      if (wvalid && wready) begin
        w_hs++; w_pend = 1; pend_data = wdata; pend_strb = wstrb;
      end
      if (aw_pend && w_pend) begin
        resp_mem[int'(pend_addr >> 2)] = merge(resp_rd(pend_addr), pend_data, pend_strb);
        aw_pend = 0; w_pend = 0;
      end
      if (rready && rvalid) r_hs++;
      if (bready && bvalid) b_hs++;
    end
  end

  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic ins, output int lat, output logic [31:0] rd,
                        output bit to, output bit stuck);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ready && lat < 300);
    to = !mem_ready;
    rd = mem_rdata;
    mem_valid = 1'b0;
    @(negedge clk);
    stuck = mem_ready;
  endtask

  task automatic test_reset();
    #3 resetn = 1'b0;
    #1;
    n_checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, mem_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {arvalid, awvalid, wvalid, rready, bready, mem_ready});
    end
    n_checks++;
    if ({mem_rdata, araddr, awaddr, wdata, wstrb, arprot, awprot} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h araddr=%h awaddr=%h wdata=%h wstrb=%b required zeros",
               mem_rdata, araddr, awaddr, wdata, wstrb);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    last_rd = '0;
  endtask

  task automatic test_read_basic();
    int lat; logic [31:0] rd; bit to, stuck; int p0;
    resp_mem[int'(32'h10 >> 2)] = 32'hDEAD_BEEF;
    ref_mem[int'(32'h10 >> 2)]  = 32'hDEAD_BEEF;
    p0 = pulses;
    do_txn(32'h0000_0010, 32'h0, 4'b0000, 1'b1, lat, rd, to, stuck);
    n_checks++;
    if (to || lat != 3) begin
      n_fail++; $display("FAIL rd_latency: got %0d (timeout=%0d) required 3", lat, to);
    end
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rd_data: got %h required deadbeef", rd);
    end
    n_checks++;
    if (last_araddr !== 32'h10 || last_arprot !== 3'b100) begin
      n_fail++; $display("FAIL rd_addr_prot: got %h/%b required 00000010/100", last_araddr, last_arprot);
    end
    n_checks++;
    if (stuck || pulses - p0 != 1) begin
      n_fail++; $display("FAIL rd_pulse: got %0d pulses stuck=%0d required 1/0", pulses - p0, stuck);
    end
    last_rd = 32'hDEAD_BEEF;
  endtask

  task automatic test_write_aw_late();
    int lat; logic [31:0] rd; bit to, stuck; int p0, a0, w0, b0;
    aw_delay = 2; w_delay = 0;
    p0 = pulses; a0 = aw_hi; w0 = w_hi; b0 = b_hs;
    do_txn(32'h0001_0004, 32'h1234_5678, 4'b0011, 1'b0, lat, rd, to, stuck);
    ref_mem[int'(32'h0001_0004 >> 2)] = merge(ref_rd(32'h0001_0004), 32'h1234_5678, 4'b0011);
    n_checks++;
    if (to || lat != 5) begin
      n_fail++; $display("FAIL wr_aw_late_latency: got %0d required 5", lat);
    end
    n_checks++;
    if (aw_hi - a0 != 3 || w_hi - w0 != 1) begin
      n_fail++; $display("FAIL wr_aw_late_hi: got aw=%0d w=%0d required 3/1", aw_hi - a0, w_hi - w0);
    end
    n_checks++;
    if (b_hs - b0 != 1 || pulses - p0 != 1 || stuck) begin
      n_fail++; $display("FAIL wr_aw_late_resp: got b=%0d pulses=%0d required 1/1", b_hs - b0, pulses - p0);
    end
    n_checks++;
    if (rd !== last_rd || last_awprot !== 3'b000) begin
      n_fail++; $display("FAIL wr_aw_late_hold: rdata=%h awprot=%b required %h/000", rd, last_awprot, last_rd);
    end
    aw_delay = 0;
  endtask

  task automatic test_write_w_late();
    int lat; logic [31:0] rd; bit to, stuck; int a0, w0, ah0, wh0;
    aw_delay = 0; w_delay = 3;
    a0 = aw_hi; w0 = w_hi; ah0 = aw_hs; wh0 = w_hs;
    do_txn(32'h0000_0200, 32'hCAFE_F00D, 4'b1111, 1'b0, lat, rd, to, stuck);
    ref_mem[int'(32'h200 >> 2)] = 32'hCAFE_F00D;
    n_checks++;
    if (aw_hi - a0 != 1 || w_hi - w0 != 4) begin
      n_fail++; $display("FAIL wr_w_late_hi: got aw=%0d w=%0d required 1/4", aw_hi - a0, w_hi - w0);
    end
    n_checks++;
    if (aw_hs - ah0 != 1 || w_hs - wh0 != 1) begin
      n_fail++; $display("FAIL wr_w_late_hs: got aw=%0d w=%0d required 1/1", aw_hs - ah0, w_hs - wh0);
    end
    n_checks++;
    if (to || lat != 6) begin
      n_fail++; $display("FAIL wr_w_late_latency: got %0d required 6", lat);
    end
    w_delay = 0;
  endtask

  task automatic test_read_ar_stall();
    int lat; logic [31:0] rd; bit to, stuck; int a0;
    ar_delay = 5;
    a0 = ar_hi;
    do_txn(32'h0001_0004, 32'h0, 4'b0000, 1'b0, lat, rd, to, stuck);
    n_checks++;
    if (ar_hi - a0 != 6) begin
      n_fail++; $display("FAIL rd_stall_arhi: got %0d required 6", ar_hi - a0);
    end
    n_checks++;
    if (to || lat != 8) begin
      n_fail++; $display("FAIL rd_stall_latency: got %0d required 8", lat);
    end
    n_checks++;
    if (rd !== ref_rd(32'h0001_0004)) begin
      n_fail++; $display("FAIL rd_stall_data: got %h required %h", rd, ref_rd(32'h0001_0004));
    end
    last_rd = ref_rd(32'h0001_0004);
    ar_delay = 0;
  endtask

  task automatic test_spurious_rvalid();
    int lat; logic [31:0] rd; bit to, stuck; int p0, r0;
    p0 = pulses; r0 = r_hs;
    spur = 1'b1;
    repeat (4) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (pulses != p0 || r_hs != r0 || mem_rdata !== last_rd) begin
      n_fail++; $display("FAIL spurious_idle: pulses=%0d rdata=%h required %0d/%h",
                         pulses, mem_rdata, p0, last_rd);
    end
    do_txn(32'h0000_0200, 32'h0, 4'b0000, 1'b0, lat, rd, to, stuck);
    n_checks++;
    if (to || rd !== 32'hCAFE_F00D || lat != 3) begin
      n_fail++; $display("FAIL spurious_read: got %h lat=%0d required cafef00d/3", rd, lat);
    end
    last_rd = 32'hCAFE_F00D;
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [31:0] rd; bit to, stuck; int act0, aw0;
    aw_delay = 10; w_delay = 10;
    aw0 = aw_hs;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0000_0300; mem_wdata = 32'h5555_AAAA; mem_wstrb = 4'b1111;
    repeat (2) @(negedge clk);
    n_checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
      n_fail++; $display("FAIL mid_wr_active: aw=%b w=%b required 1/1", awvalid, wvalid);
    end
    #2 resetn = 1'b0;
    mem_valid = 1'b0;
    #1;
    n_checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || mem_rdata !== '0) begin
      n_fail++; $display("FAIL mid_wr_abort: aw=%b w=%b rdata=%h required 0/0/0", awvalid, wvalid, mem_rdata);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    last_rd = '0;
    act0 = act;
    repeat (6) @(negedge clk);
    n_checks++;
    if (act != act0 || aw_hs != aw0) begin
      n_fail++; $display("FAIL post_reset_quiet: act=%0d aw_hs=%0d required %0d/%0d", act, aw_hs, act0, aw0);
    end
    aw_delay = 0; w_delay = 0;
    do_txn(32'h0000_0300, 32'h0, 4'b0000, 1'b0, lat, rd, to, stuck);
    n_checks++;
    if (to || rd !== ref_rd(32'h300)) begin
      n_fail++; $display("FAIL post_reset_read: got %h required %h", rd, ref_rd(32'h300));
    end
    last_rd = ref_rd(32'h300);
  endtask

  task automatic test_random();
    int lat, exp_lat, m; logic [31:0] rd, a, d; logic [3:0] s; logic ins; bit to, stuck;
    for (int i = 0; i < 40; i++) begin
      a = 32'h100 + {26'd0, 4'($urandom_range(0, 7)), 2'b00};
      d = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      ins = 1'($urandom_range(0, 1));
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3);
      do_txn(a, d, s, ins, lat, rd, to, stuck);
      if (s == 4'b0000) begin
        exp_lat = 3 + ar_delay + r_delay;
        n_checks++;
        if (to || rd !== ref_rd(a) || last_arprot !== {ins, 2'b00}) begin
          n_fail++; $display("FAIL rand_read[%0d]: got %h prot=%b required %h/%b",
                             i, rd, last_arprot, ref_rd(a), {ins, 2'b00});
        end
        last_rd = ref_rd(a);
      end else begin
        m = (aw_delay > w_delay) ? aw_delay : w_delay;
        exp_lat = 3 + m + b_delay;
        ref_mem[int'(a >> 2)] = merge(ref_rd(a), d, s);
        n_checks++;
        if (to || rd !== last_rd) begin
          n_fail++; $display("FAIL rand_write_hold[%0d]: rdata=%h required %h", i, rd, last_rd);
        end
      end
      n_checks++;
      if (lat != exp_lat || stuck) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d stuck=%0d required %0d/0", i, lat, stuck, exp_lat);
      end
    end
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_aw_late();
    test_write_w_late();
    test_read_ar_stall();
    test_spurious_rvalid();
    test_reset_mid_write();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/native_axi_master.md
NATIVE_AXI_MASTER -- requirements
Module: native_axi_master

Interface
REQ-001 SHALL have parameters: none; the address map and memory sizing belong to the AXI responder.
REQ-002 SHALL have one clock and one reset. The reset is asynchronous and active-low.
REQ-003 SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  native request valid; held high by the CPU until mem_ready
- mem_instr  in  1  request is an instruction fetch
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables; 4'b0000 means read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- mem_axi_awvalid / awready  out / in  1  AXI4-lite write-address handshake
- mem_axi_awaddr  out  32  write address
- mem_axi_awprot  out  3  write protection
- mem_axi_wvalid / wready  out / in  1  write-data handshake
- mem_axi_wdata  out  32  write data
- mem_axi_wstrb  out  4  write strobes
- mem_axi_bvalid / bready  in / out  1  write-response handshake
- mem_axi_arvalid / arready  out / in  1  read-address handshake
- mem_axi_araddr  out  32  read address
- mem_axi_arprot  out  3  read protection
- mem_axi_rvalid / rready  in / out  1  read-data handshake
- mem_axi_rdata  in  32  read data

Function
REQ-004 SHALL register all outputs; there SHALL be no combinational path from any input to any output.
REQ-005 SHALL implement the FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP and DONE.
REQ-006 In IDLE, at an edge with mem_valid=1, SHALL latch mem_addr, mem_wdata, mem_wstrb and mem_instr. It SHALL go to RD_ADDR if wstrb==0, otherwise to WR_REQ.
REQ-007 RD_ADDR: arvalid=1 and araddr=latched address. arprot SHALL be 3'b100 if instr, else 3'b000. On an edge with arready=1: arvalid->0, rready->1, go to RD_DATA.
REQ-008 RD_DATA: rready=1. On an edge with rvalid=1: capture rdata into mem_rdata, rready->0, go to DONE.
REQ-009 WR_REQ: awvalid=1 and wvalid=1, asserted in the same cycle. awaddr, wdata and wstrb SHALL be the latched values; awprot SHALL be 3'b000.
REQ-010 In WR_REQ, awvalid and wvalid SHALL each drop independently on their own handshake edge. Two flags, aw_done and w_done, SHALL record completion. When both are done (including the same edge): bready->1, go to WR_RESP.
REQ-011 WR_RESP: bready=1. On an edge with bvalid=1: bready->0, go to DONE.
REQ-012 DONE: mem_ready=1 for exactly one cycle, then IDLE. No new request SHALL be sampled in the DONE cycle.
REQ-013 A valid signal, once asserted, SHALL stay high with address, data and strobes stable until its ready is sampled high.
REQ-014 At most one AXI transaction SHALL be outstanding. arvalid and awvalid SHALL never be high together.
REQ-015 rready SHALL be 1 only in RD_DATA and bready only in WR_RESP. rvalid or bvalid in any other state SHALL be ignored.
REQ-016 mem_rdata SHALL hold its last read value across writes and idle cycles.
REQ-017 Latency with a zero-wait responder: read mem_ready 3 cycles after the sampling edge; write mem_ready 3 cycles after the sampling edge.
REQ-018 There SHALL be no timeout; a stalled responder stalls the bridge indefinitely.

Reset
REQ-019 While resetn=0, asynchronously: all AXI valid/ready outputs=0, mem_ready=0, mem_rdata=0, addr/data/strb/prot outputs=0, flags cleared, FSM=IDLE.
REQ-020 Reset asserted mid-transaction SHALL abort it with no further handshakes. After release, the bridge SHALL start only on a fresh mem_valid sample.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Read 0x00000010, instr=1, responder arready=1 and rvalid=1 with rdata=0xDEADBEEF. Expect araddr=0x10, arprot=3'b100, mem_rdata=0xDEADBEEF, and a one-cycle mem_ready 3 cycles after sampling.
- Write 0x00010004, wdata=0x12345678, wstrb=4'b0011; awready delayed 2 cycles, wready immediate. Expect wvalid to drop first, awvalid held stable until its handshake, then bready, then a single mem_ready.
- Write with wready delayed 3 cycles and awready immediate. Expect awvalid high exactly 1 cycle, wvalid high 4 cycles, and no duplicate handshake.
- Read with arready held low for 5 cycles. Expect arvalid and araddr stable for 6 cycles, and mem_ready not asserted early.
- Inject a spurious rvalid=1 during IDLE, then issue a read. Expect no mem_ready from the spurious beat, and rdata captured only in RD_DATA.
- Assert resetn=0 mid-WR_REQ. Expect awvalid=wvalid=0 immediately, and after release no activity until mem_valid=1.
